inst_fetch_queue: RTL and testbench

Instruction-fetch front end that drives the asynchronous-read instruction memory's address port and captures the returned word each cycle. Fetched {pc, inst} pairs are buffered in a small FIFO. The FIFO feeds the decode stage through a valid/ready handshake. Sits between the PC/branch-resolution logic and the IF/ID pipeline register; a redirect from EX flushes the queue and restarts fetch at the target.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/ifq_fifo.sv | 71 +++++++
 rtl/inst_fetch_queue.sv | 96 +++++++++
 tb/tb_inst_fetch_queue.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Widths of the {pc, inst} pair stored in the fetch queue.
package fetch_pkg;

    localparam int          INST_W           = 32;
    localparam int          PC_W             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Small flushable FIFO of fetch entries with a combinational head read.
// Flush and reset both empty the queue; stored entries are left as-is.
module ifq_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop,
    output fetch_entry_t       head_entry,
    output logic [CNT_W-1:0]   count,
    output logic               empty,
    output logic               full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;
    fetch_entry_t     entry_reg [DEPTH];

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    // One write-enabled register bank per entry; contents need no reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg[gi] <= push_entry;
                end
            end
        end
    endgenerate

    assign head_entry = entry_reg[rd_ptr_reg];
    assign count      = count_reg;

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: drives imem address from fetch_pc, queues {pc, inst} pairs.
// Optional stall counter port enabled by defining IFQ_STALL_CNT_EN.
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 4,
    parameter int          CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    output logic [31:0]        imem_addr,
    input  logic [31:0]        imem_dout,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_inst,
    output logic [CNT_W-1:0]   queue_count
`ifdef IFQ_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);

    logic [PC_W-1:0] fetch_pc_reg;
    logic [PC_W-1:0] fetch_pc_next;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            fifo_full;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    assign push = fetch_en & ~reset & ~redirect_valid & ~fifo_full;
    assign pop  = out_valid & out_ready;

    assign push_entry.pc   = fetch_pc_reg;
    assign push_entry.inst = imem_dout;

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc & ~32'h3;
        end else if (push) begin
            fetch_pc_next = fetch_pc_reg + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_reg <= RESET_PC;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .count      (queue_count),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    assign imem_addr = fetch_pc_reg;
    assign out_valid = ~fifo_empty;
    // Head storage is don't-care while empty, so present zeros instead.
    assign out_pc    = out_valid ? head_entry.pc   : '0;
    assign out_inst  = out_valid ? head_entry.inst : '0;

`ifdef IFQ_STALL_CNT_EN
    logic [31:0] stall_cycles_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_reg <= '0;
        end else if (fetch_en && !redirect_valid && fifo_full && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: queue-based reference model plus directed checks.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             fetch_en = 1'b0;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_dout;
    logic             redirect_valid = 1'b0;
    logic [31:0]      redirect_pc = 32'h0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_pc;
    logic [31:0]      out_inst;
    logic [CNT_W-1:0] queue_count;
`ifdef IFQ_STALL_CNT_EN
    logic [31:0]      stall_cycles;
    logic [31:0]      stall_cycles2;
`endif

    // Second instance exercising the PC wrap, memory stub returns the address.
    logic [31:0]      imem_addr2;
    logic             out_valid2;
    logic [31:0]      out_pc2;
    logic [31:0]      out_inst2;
    logic [CNT_W-1:0] queue_count2;
    logic             fetch_en2 = 1'b1;
    logic             out_ready2 = 1'b1;
    logic             redirect_valid2 = 1'b0;
    logic [31:0]      redirect_pc2 = 32'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory stub: word i holds i + 100.
    assign imem_dout = (imem_addr >> 2) + 32'd100;

    inst_fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_dout      (imem_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .queue_count    (queue_count)
`ifdef IFQ_STALL_CNT_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    inst_fetch_queue #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_wrap (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en2),
        .imem_addr      (imem_addr2),
        .imem_dout      (imem_addr2),
        .redirect_valid (redirect_valid2),
        .redirect_pc    (redirect_pc2),
        .out_valid      (out_valid2),
        .out_ready      (out_ready2),
        .out_pc         (out_pc2),
        .out_inst       (out_inst2),
        .queue_count    (queue_count2)
`ifdef IFQ_STALL_CNT_EN
        ,
        .stall_cycles   (stall_cycles2)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural queue of {pc, inst} and the next fetch PC.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } item_t;

    item_t       exp_q[$];
    logic [31:0] m_pc;
    bit          model_ok = 0;

    always @(negedge clk) begin
        item_t it;
        bit    do_pop;
        bit    do_push;
        if (model_ok) begin
            check("mon_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
            check("mon_count", 32'(queue_count), 32'(exp_q.size()));
            check("mon_addr", imem_addr, m_pc);
            if (exp_q.size() != 0) begin
                check("mon_pc", out_pc, exp_q[0].pc);
                check("mon_inst", out_inst, exp_q[0].inst);
            end else begin
                check("mon_pc_empty", out_pc, 32'h0);
            end
        end
        if (reset) begin
            exp_q.delete();
            m_pc     = 32'h0;
            model_ok = 1;
        end else if (model_ok) begin
            do_pop  = (exp_q.size() != 0) && out_ready;
            do_push = fetch_en && !redirect_valid && (exp_q.size() < DEPTH);
            if (do_pop) begin
                it = exp_q.pop_front();
                $display("POP pc=%h inst=%h", it.pc, it.inst);
            end
            if (redirect_valid) begin
                exp_q.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end else if (do_push) begin
                it.pc   = m_pc;
                it.inst = m_pc / 4 + 32'd100;
                exp_q.push_back(it);
                m_pc = m_pc + 32'd4;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        // Streaming from reset with decode always ready.
        reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("rst_count", 32'(queue_count), 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_pc", out_pc, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("stream_pc", out_pc, 32'(i * 4));
            check("stream_inst", out_inst, 32'(100 + i));
        end

        // Backpressure fills the queue; fetch_pc must hold.
        tick(); reset = 1'b1;
        tick(); reset = 1'b0; out_ready = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        check("full_count", 32'(queue_count), 32'd4);
        check("full_addr", imem_addr, 32'h10);
        check("full_head", out_pc, 32'h0);
        tick(); out_ready = 1'b1;
        repeat (6) tick();

        // Redirect with three entries queued.
        reset = 1'b1;
        tick(); reset = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h43;
        @(negedge clk);
        check("pre_redir_count", 32'(queue_count), 32'd3);
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_count", 32'(queue_count), 32'd0);
        check("redir_addr", imem_addr, 32'h40);
        tick();
        @(negedge clk);
        check("redir_valid", {31'b0, out_valid}, 32'h1);
        check("redir_pc", out_pc, 32'h40);
        check("redir_inst", out_inst, 32'd116);

        // Redirect coinciding with a pop and a would-be push.
        tick(); out_ready = 1'b1;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h202;
        @(negedge clk);
        check("coinc_valid", {31'b0, out_valid}, 32'h1);
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        check("coinc_count", 32'(queue_count), 32'd0);
        check("coinc_addr", imem_addr, 32'h200);

        // Randomized traffic checked by the scoreboard.
        for (int n = 0; n < 800; n++) begin
            tick();
            fetch_en       = ($urandom_range(0, 9) < 8);
            out_ready      = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 99) < 4);
            redirect_pc    = $urandom & 32'h000F_FFFF;
            reset          = ($urandom_range(0, 199) == 0);
        end
        tick();
        reset = 1'b1; redirect_valid = 1'b0;

        // PC wrap on the second instance.
        tick(); reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("wrap_rst_valid", {31'b0, out_valid2}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] wpc;
            wpc = 32'hFFFF_FFF8 + 32'(i * 4);
            tick();
            @(negedge clk);
            check("wrap_pc", out_pc2, wpc);
            check("wrap_inst", out_inst2, wpc);
        end

`ifdef IFQ_STALL_CNT_EN
        tick(); reset = 1'b1;
        tick(); reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        check("stall_cnt", stall_cycles, 32'd16);
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        @(negedge clk);
        check("stall_rst", stall_cycles, 32'h0);
        check("stall_rst_count", 32'(queue_count), 32'h0);
        check("stall_rst_addr", imem_addr, 32'h0);
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
